freelist_mp: RTL and testbench
==============================

// Module: freelist_mp
// PURPOSE
// - Parametrised physical-register free list for the rename stage; successor to the fixed-width int freelist.
// - Circular pool of free PR indices with three pointers:
//   - spec head (rename allocation)
//   - commit head (architectural allocation)
//   - tail (dealloc returns)
// - Independent ALLOC_WIDTH / DEALLOC_WIDTH / COMMIT_WID, compacted (holey) request vectors, resteer recovery in one cycle.
// PARAMETERS
// - NUM_PHYREG    64  total physical regs; NUM_PHYREG-NUM_ARCHREG must be a power of two
// - NUM_ARCHREG   32  PRs 0..NUM_ARCHREG-1 hold the reset arch mapping, never in pool at reset
// - ALLOC_WIDTH    4  rename lanes requesting a PR per cycle
// - DEALLOC_WIDTH  4  PRs returned per cycle (from rat_map dealloc)
// - COMMIT_WID     4  commit lanes that consumed a PR
// - prIdx_t   iprIdx_t  PR index type, $clog2(NUM_PHYREG) bits
// PORTS
// - clk              in   1              clock
// - rst              in   1              sync active-high reset
// - o_can_alloc      out  1              spec free count >= ALLOC_WIDTH
// - i_alloc_req      in   ALLOC_WIDTH    per-lane request; may have holes
// - o_alloc_prIdx    out  prIdx_t[ALLOC_WIDTH]  PR for each lane (valid where req set)
// - i_dealloc_req    in   DEALLOC_WIDTH  per-lane PR return; may have holes
// - i_dealloc_prIdx  in   prIdx_t[DEALLOC_WIDTH] PRs returned
// - i_commit_vld     in   COMMIT_WID     lanes committing an allocating instr (has_rd & ~ismv)
// - i_resteer_vld    in   1              squash: roll spec head back to commit head
// - o_free_count     out  $clog2(D)+1    spec-visible free entries, D=NUM_PHYREG-NUM_ARCHREG
// - o_err            out  1              sticky error (see CONFIGURATION)
// BEHAVIOUR
// - Storage: D-entry array; pointers $clog2(D)+1 bits (MSB = wrap bit).
// - Reset:
//   - entry[i] = NUM_ARCHREG+i.
//   - spec_head = commit_head = 0; tail = D with wrap bit set, i.e. pool full.
//   - o_free_count = D, o_can_alloc = 1, o_err = 0.
// - Free count: tail - spec_head, full pointer-width subtract, so full and empty are distinguished by the wrap bit.
// - Alloc (combinational outputs, registered state):
//   - o_alloc_prIdx[k] = entry[spec_head + popcount(i_alloc_req[k-1:0])].
//   - Consume fires iff o_can_alloc & ~i_resteer_vld; then spec_head += popcount(i_alloc_req).
//   - Requests while o_can_alloc=0 are ignored, with no pointer change.
// - Dealloc:
//   - Lane j with req set is written to entry[tail + popcount(i_dealloc_req[j-1:0])].
//   - tail += popcount(i_dealloc_req); visible to alloc next cycle, no bypass.
// - Commit: commit_head += popcount(i_commit_vld) every cycle, including during resteer.
// - Resteer: spec_head <= commit_head + popcount(i_commit_vld), i.e. same-cycle commit is included. Alloc that cycle is dropped.
// - Simultaneous alloc+dealloc+commit: all applied in one cycle; dealloc never blocked.
// - Wrap-around: pointers wrap modulo 2*D. Index = ptr[$clog2(D)-1:0].
// - Invariants, enforced by the upstream ROB/RAT and not by this block:
//   - commit_head <= spec_head <= tail (modulo).
//   - Dealloc never exceeds D - (tail - commit_head).
// - Mid-operation reset: all pointers and entries return to reset contents the next cycle. Inputs on the reset cycle are ignored.
// CONFIGURATION
// - FREELIST_DUPCHECK_EN defined:
//   - Adds a NUM_PHYREG-bit free bitmap, reset to 1 for PRs >= NUM_ARCHREG.
//   - Consumed alloc clears the bit; dealloc sets it.
//   - o_err sets (sticky until rst) on either of:
//     - dealloc of a PR whose bit is already 1 (double free);
//     - dealloc of PR < NUM_ARCHREG before it was ever allocated.
//   - Resteer restores bits of rolled-back PRs by re-marking entries [commit_head', old spec_head) as free.
// - FREELIST_DUPCHECK_EN undefined: no bitmap; o_err tied 0.
// TESTING
// - Reset, D=32, W=4 -> lanes req=4'b1111 -> alloc 32,33,34,35; free_count 32->28 next cycle.
// - req=4'b1010 -> lane1=PR32, lane3=PR33; spec_head +2.
// - Alloc 4/cycle x8 -> free_count 0, o_can_alloc=0; further reqs leave free_count at 0.
// - Alloc 12, commit 4, resteer with commit=2'b11 same cycle -> free_count = 32-6 = 26; next alloc returns PR38.
// - Free pool fully, commit all, dealloc PR0..3 repeatedly across tail wrap -> returned PRs reappear in FIFO order after wrap; no loss.
// - FREELIST_DUPCHECK_EN: dealloc PR40 while still free -> o_err=1 next cycle, stays 1 until rst.

Source files
------------

// File: rtl/freelist_mp_if.sv
// Bundle of rename-side signals for the multi-port physical-register free list.
// The master modport is the rename/ROB side; the slave modport is the free list.
interface freelist_mp_if #(
  parameter int NUM_PHYREG    = 64,
  parameter int NUM_ARCHREG   = 32,
  parameter int ALLOC_WIDTH   = 4,
  parameter int DEALLOC_WIDTH = 4,
  parameter int COMMIT_WID    = 4
);
  localparam int PR_W  = $clog2(NUM_PHYREG);
  localparam int CNT_W = $clog2(NUM_PHYREG - NUM_ARCHREG) + 1;

  typedef logic [PR_W-1:0] prIdx_t;

  logic                        o_can_alloc;
  logic [ALLOC_WIDTH-1:0]      i_alloc_req;
  prIdx_t [ALLOC_WIDTH-1:0]    o_alloc_prIdx;
  logic [DEALLOC_WIDTH-1:0]    i_dealloc_req;
  prIdx_t [DEALLOC_WIDTH-1:0]  i_dealloc_prIdx;
  logic [COMMIT_WID-1:0]       i_commit_vld;
  logic                        i_resteer_vld;
  logic [CNT_W-1:0]            o_free_count;
  logic                        o_err;

  modport master (
    input  o_can_alloc, o_alloc_prIdx, o_free_count, o_err,
    output i_alloc_req, i_dealloc_req, i_dealloc_prIdx, i_commit_vld, i_resteer_vld
  );

  modport slave (
    output o_can_alloc, o_alloc_prIdx, o_free_count, o_err,
    input  i_alloc_req, i_dealloc_req, i_dealloc_prIdx, i_commit_vld, i_resteer_vld
  );
endinterface

// File: rtl/freelist_mp.sv
// Physical-register free list for the rename stage.
// Circular pool of D = NUM_PHYREG-NUM_ARCHREG free PR indices with a speculative
// head (rename allocation), a commit head (architectural allocation) and a tail
// (returned PRs). Pointers carry one extra wrap bit so full and empty differ.
// Optional macro FREELIST_DUPCHECK_EN adds a free bitmap that flags double frees
// and frees of never-allocated architectural PRs on a sticky o_err.
module freelist_mp #(
  parameter int NUM_PHYREG    = 64,
  parameter int NUM_ARCHREG   = 32,
  parameter int ALLOC_WIDTH   = 4,
  parameter int DEALLOC_WIDTH = 4,
  parameter int COMMIT_WID    = 4
) (
  input  logic          clk,
  input  logic          rst,
  freelist_mp_if.slave  fl
);
  localparam int D     = NUM_PHYREG - NUM_ARCHREG;
  localparam int IDX_W = $clog2(D);
  localparam int PTR_W = IDX_W + 1;
  localparam int PR_W  = $clog2(NUM_PHYREG);

  typedef logic [PR_W-1:0]  prIdx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  prIdx_t entry_q [D];
  ptr_t   spec_head_q;
  ptr_t   commit_head_q;
  ptr_t   tail_q;

  ptr_t   free_count;
  ptr_t   alloc_cnt;
  ptr_t   dealloc_cnt;
  ptr_t   commit_cnt;
  ptr_t   commit_head_new;
  ptr_t   alloc_ptr   [ALLOC_WIDTH];
  ptr_t   dealloc_ptr [DEALLOC_WIDTH];
  logic   can_alloc;
  logic   alloc_fire;

  assign free_count      = tail_q - spec_head_q;
  assign can_alloc       = (free_count >= ptr_t'(ALLOC_WIDTH));
  assign alloc_fire      = can_alloc & ~fl.i_resteer_vld;
  assign fl.o_free_count = free_count;
  assign fl.o_can_alloc  = can_alloc;

  // Compact holey alloc requests: each requesting lane takes the next pool slot.
  always_comb begin
    alloc_cnt = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      alloc_ptr[k] = spec_head_q + alloc_cnt;
      alloc_cnt    = alloc_cnt + ptr_t'(fl.i_alloc_req[k]);
    end
  end

  // Present the pool entry each lane would receive (meaningful where requested).
  always_comb begin
    fl.o_alloc_prIdx = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      fl.o_alloc_prIdx[k] = entry_q[alloc_ptr[k][IDX_W-1:0]];
    end
  end

  // Compact holey dealloc returns onto consecutive slots starting at the tail.
  always_comb begin
    dealloc_cnt = '0;
    for (int j = 0; j < DEALLOC_WIDTH; j++) begin
      dealloc_ptr[j] = tail_q + dealloc_cnt;
      dealloc_cnt    = dealloc_cnt + ptr_t'(fl.i_dealloc_req[j]);
    end
  end

  // Count committing lanes; the advanced commit head is also the resteer target.
  always_comb begin
    commit_cnt = '0;
    for (int c = 0; c < COMMIT_WID; c++) begin
      commit_cnt = commit_cnt + ptr_t'(fl.i_commit_vld[c]);
    end
    commit_head_new = commit_head_q + commit_cnt;
  end

  // Pointer update: commit and dealloc always apply; resteer overrides alloc.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= ptr_t'(D);
    end else begin
      commit_head_q <= commit_head_new;
      tail_q        <= tail_q + dealloc_cnt;
      if (fl.i_resteer_vld) begin
        spec_head_q <= commit_head_new;
      end else if (alloc_fire) begin
        spec_head_q <= spec_head_q + alloc_cnt;
      end
    end
  end

  // Pool storage: reset to the non-architectural PRs, written by returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        entry_q[i] <= prIdx_t'(NUM_ARCHREG + i);
      end
    end else begin
      for (int j = 0; j < DEALLOC_WIDTH; j++) begin
        if (fl.i_dealloc_req[j]) begin
          entry_q[dealloc_ptr[j][IDX_W-1:0]] <= fl.i_dealloc_prIdx[j];
        end
      end
    end
  end

`ifdef FREELIST_DUPCHECK_EN
  logic [NUM_PHYREG-1:0] free_map_q;
  logic [NUM_PHYREG-1:0] free_map_d;
  logic [NUM_PHYREG-1:0] ever_alloc_q;
  logic [NUM_PHYREG-1:0] ever_alloc_d;
  logic                  err_q;
  logic                  err_d;
  ptr_t                  roll_cnt;

  // Track which PRs are free; flag double frees and frees of unallocated arch PRs.
  always_comb begin
    free_map_d   = free_map_q;
    ever_alloc_d = ever_alloc_q;
    err_d        = err_q;
    roll_cnt     = spec_head_q - commit_head_new;
    if (alloc_fire) begin
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        if (fl.i_alloc_req[k]) begin
          free_map_d[fl.o_alloc_prIdx[k]]   = 1'b0;
          ever_alloc_d[fl.o_alloc_prIdx[k]] = 1'b1;
        end
      end
    end
    if (fl.i_resteer_vld) begin
      for (int i = 0; i < D; i++) begin
        if (ptr_t'(i) < roll_cnt) begin
          free_map_d[entry_q[IDX_W'(commit_head_new[IDX_W-1:0] + IDX_W'(i))]] = 1'b1;
        end
      end
    end
    for (int j = 0; j < DEALLOC_WIDTH; j++) begin
      if (fl.i_dealloc_req[j]) begin
        if (free_map_q[fl.i_dealloc_prIdx[j]] ||
            ((int'(fl.i_dealloc_prIdx[j]) < NUM_ARCHREG) && !ever_alloc_q[fl.i_dealloc_prIdx[j]])) begin
          err_d = 1'b1;
        end
        free_map_d[fl.i_dealloc_prIdx[j]] = 1'b1;
      end
    end
  end

  // Bitmap and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYREG; i++) begin
        free_map_q[i] <= (i >= NUM_ARCHREG);
      end
      ever_alloc_q <= '0;
      err_q        <= 1'b0;
    end else begin
      free_map_q   <= free_map_d;
      ever_alloc_q <= ever_alloc_d;
      err_q        <= err_d;
    end
  end

  assign fl.o_err = err_q;
`else
  assign fl.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_mp.sv
// Directed self-checking bench for freelist_mp with default parameters
// (D = 32 pool entries, 4 lanes each). Expected values are hand-computed.
module tb_freelist_mp;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  freelist_mp_if fl_if ();

  freelist_mp dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] areq, input logic [3:0] dreq,
                               input logic [3:0][5:0] dpr, input logic [3:0] cvld,
                               input logic rsv);
    fl_if.i_alloc_req     = areq;
    fl_if.i_dealloc_req   = dreq;
    fl_if.i_dealloc_prIdx = dpr;
    fl_if.i_commit_vld    = cvld;
    fl_if.i_resteer_vld   = rsv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(4'b0000, 4'b0000, '0, 4'b0000, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Directed scenarios.
  initial begin
    logic [3:0][5:0] dv;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_free_count", 32'(fl_if.o_free_count), 32);
    checkOutput("rst_can_alloc", 32'(fl_if.o_can_alloc), 1);
    checkOutput("rst_err", 32'(fl_if.o_err), 0);

    $display("[TB] full 4-lane alloc");
    applyStimulus(4'b1111, 4'b0000, '0, 4'b0000, 1'b0);
    checkOutput("alloc4_lane0", 32'(fl_if.o_alloc_prIdx[0]), 32);
    checkOutput("alloc4_lane1", 32'(fl_if.o_alloc_prIdx[1]), 33);
    checkOutput("alloc4_lane2", 32'(fl_if.o_alloc_prIdx[2]), 34);
    checkOutput("alloc4_lane3", 32'(fl_if.o_alloc_prIdx[3]), 35);
    tick();
    idle();
    checkOutput("alloc4_free_count", 32'(fl_if.o_free_count), 28);

    $display("[TB] holey alloc");
    doReset();
    applyStimulus(4'b1010, 4'b0000, '0, 4'b0000, 1'b0);
    checkOutput("holey_lane1", 32'(fl_if.o_alloc_prIdx[1]), 32);
    checkOutput("holey_lane3", 32'(fl_if.o_alloc_prIdx[3]), 33);
    tick();
    idle();
    checkOutput("holey_free_count", 32'(fl_if.o_free_count), 30);
    applyStimulus(4'b1111, 4'b0000, '0, 4'b0000, 1'b0);
    checkOutput("holey_next_lane0", 32'(fl_if.o_alloc_prIdx[0]), 34);

    $display("[TB] drain to empty");
    doReset();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(4'b1111, 4'b0000, '0, 4'b0000, 1'b0);
      tick();
    end
    checkOutput("drain_free_count_4", 32'(fl_if.o_free_count), 4);
    checkOutput("drain_can_alloc_4", 32'(fl_if.o_can_alloc), 1);
    tick();
    checkOutput("drain_free_count_0", 32'(fl_if.o_free_count), 0);
    checkOutput("drain_can_alloc_0", 32'(fl_if.o_can_alloc), 0);
    tick();
    idle();
    checkOutput("drain_ignored_req", 32'(fl_if.o_free_count), 0);

    $display("[TB] resteer with same-cycle commit");
    doReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 4'b0000, '0, 4'b0000, 1'b0);
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, '0, 4'b1111, 1'b0);
    tick();
    applyStimulus(4'b1111, 4'b0000, '0, 4'b0011, 1'b1);
    tick();
    idle();
    checkOutput("resteer_free_count", 32'(fl_if.o_free_count), 26);
    applyStimulus(4'b1111, 4'b0000, '0, 4'b0000, 1'b0);
    checkOutput("resteer_lane0", 32'(fl_if.o_alloc_prIdx[0]), 38);
    checkOutput("resteer_lane3", 32'(fl_if.o_alloc_prIdx[3]), 41);

    $display("[TB] simultaneous alloc, dealloc and commit");
    doReset();
    applyStimulus(4'b1111, 4'b0000, '0, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, '0, 4'b1111, 1'b0);
    tick();
    applyStimulus(4'b1111, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, 4'b0001, 1'b0);
    checkOutput("simul_lane0", 32'(fl_if.o_alloc_prIdx[0]), 36);
    tick();
    idle();
    checkOutput("simul_free_count", 32'(fl_if.o_free_count), 25);

    $display("[TB] dealloc across tail wrap");
    doReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 4'b0000, '0, 4'b0000, 1'b0);
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0000, 4'b0000, '0, 4'b1111, 1'b0);
      tick();
    end
    idle();
    checkOutput("wrap_empty", 32'(fl_if.o_free_count), 0);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        dv[j] = 6'((i * 4 + j * 9 + 1) % 64);
      end
      applyStimulus(4'b0000, 4'b1111, dv, 4'b0000, 1'b0);
      tick();
      idle();
      checkOutput("wrap_free_count", 32'(fl_if.o_free_count), 4);
      applyStimulus(4'b1111, 4'b0000, '0, 4'b1111, 1'b0);
      for (int j = 0; j < 4; j++) begin
        checkOutput("wrap_lane", 32'(fl_if.o_alloc_prIdx[j]), int'(dv[j]));
      end
      tick();
    end
    idle();
    checkOutput("wrap_final_empty", 32'(fl_if.o_free_count), 0);

    $display("[TB] holey dealloc");
    applyStimulus(4'b0000, 4'b0101, {6'd63, 6'd20, 6'd63, 6'd10}, 4'b0000, 1'b0);
    tick();
    idle();
    checkOutput("hdealloc_free_count", 32'(fl_if.o_free_count), 2);
    checkOutput("hdealloc_can_alloc", 32'(fl_if.o_can_alloc), 0);
    applyStimulus(4'b0011, 4'b0000, '0, 4'b0000, 1'b0);
    checkOutput("hdealloc_lane0", 32'(fl_if.o_alloc_prIdx[0]), 10);
    checkOutput("hdealloc_lane1", 32'(fl_if.o_alloc_prIdx[1]), 20);
    tick();
    idle();
    checkOutput("hdealloc_blocked", 32'(fl_if.o_free_count), 2);

`ifdef FREELIST_DUPCHECK_EN
    $display("[TB] double free detection");
    doReset();
    applyStimulus(4'b0000, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd40}, 4'b0000, 1'b0);
    tick();
    idle();
    checkOutput("dup_err_set", 32'(fl_if.o_err), 1);
    tick();
    checkOutput("dup_err_sticky", 32'(fl_if.o_err), 1);
    doReset();
    checkOutput("dup_err_cleared", 32'(fl_if.o_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
